apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
APB4 master-side sequencer for the AXI4Lite-to-APB4 bridge. It accepts a one-cycle read or write grant from the bridge's access arbiter and captures the address, data and control of the granted request. It then drives the APB4 SETUP and ACCESS phases, absorbs PREADY wait states and reports completion back to the arbiter and the response channels. A programmable timeout ends a hung transfer with an error response.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (strobe width = DATA_W/8)
TIMEOUT, 16, max ACCESS cycles waiting for pready; 0 = no timeout

Ports:
clk  in  1  bridge clock
rstn  in  1  asynchronous active-low reset
rd_en  in  1  read grant pulse from arbiter
wr_en  in  1  write grant pulse from arbiter
rd_addr  in  ADDR_W  read request address
rd_prot  in  3  read request protection
wr_addr  in  ADDR_W  write request address
wr_data  in  DATA_W  write data
wr_strb  in  DATA_W/8  write byte strobes
wr_prot  in  3  write request protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes (0 on reads)
pprot  out  3  APB protection
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
rd_done  out  1  read complete pulse (to arbiter rd and read response channel)
rd_data  out  DATA_W  captured read data, valid with rd_done
rd_resp  out  2  read response, valid with rd_done
wr_done  out  1  write complete pulse (to arbiter wr and write response channel)
wr_resp  out  2  write response, valid with wr_done
busy  out  1  high in SETUP or ACCESS

Behaviour:
- Reset (async, rstn low): state IDLE, every output 0, timeout counter 0. Takes effect immediately, even mid-transfer.
- FSM states:
  - IDLE: accept a grant.
  - SETUP: psel=1, penable=0; unconditional move to ACCESS.
  - ACCESS: psel=1, penable=1; holds until pready=1 or timeout.
- Grants:
  - Sampled only in IDLE.
  - rd_en and wr_en together in the same cycle is an arbiter error; read wins and the write grant is dropped.
  - Grants arriving in SETUP or ACCESS are ignored.
- Capture: on the grant cycle, load paddr/pprot/pwrite (plus pwdata/pstrb for writes) from the granted channel. For a read, pstrb=0 and pwdata holds its previous value. Values hold stable through SETUP and ACCESS and persist in IDLE until the next grant.
- Phase timing: grant at cycle N -> SETUP at N+1 -> ACCESS at N+2.
- Completion in ACCESS with pready=1:
  - The next cycle is IDLE with psel=penable=0.
  - The matching done pulse is high for exactly that one IDLE cycle.
  - rd_data = prdata sampled with pready.
  - resp = pslverr ? 2'b10 : 2'b00.
- Back-to-back: a grant in the done cycle is accepted, so the minimum transfer period is 3 cycles and psel is low for 1 cycle between transfers.
- Response fields: rd_data, rd_resp and wr_resp hold their values until the next completion of the same type.
- Timeout (TIMEOUT>0):
  - Counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT and pready is still 0, the transfer terminates as if completed.
  - resp = 2'b10; rd_data = 0 for reads.
  - pready=1 on the same cycle as expiry wins: normal completion.
- TIMEOUT=0: wait indefinitely; counter inactive.
- busy = SETUP or ACCESS. rd_done and wr_done are never high together.

Test Plan:
- Write, zero wait: wr_en with wr_addr=0x40, wr_data=0xDEADBEEF, wr_strb=0xF, pready=1 -> psel at N+1, penable at N+2, pwrite=1, wr_done at N+3, wr_resp=00.
- Read, 3 wait states: rd_en with rd_addr=0x10; pready low 3 ACCESS cycles, then high with prdata=0x12345678, pslverr=1 -> rd_done at N+6, rd_data=0x12345678, rd_resp=10, pstrb=0.
- Simultaneous grants: rd_en=wr_en=1 -> read transfer only, pwrite=0, no wr_done. Back-to-back wr_en in the done cycle -> next SETUP one cycle later.
- Timeout: TIMEOUT=4, pready stuck low -> termination after 4 ACCESS cycles, psel drops, rd_resp=10, rd_data=0. Repeat with pready rising on the expiry cycle -> normal OKAY completion.
- Reset mid-ACCESS: rstn low while psel=penable=1 -> all outputs 0 immediately. After release, a new grant runs a clean transfer.
- Grant while busy: wr_en pulsed during ACCESS -> ignored, exactly one transfer and one done pulse.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB4 master sequencer (grant capture, SETUP/ACCESS, wait states, timeout)
// Ports: clk/rstn clock and async active-low reset; rd_*/wr_* grant pulses and request fields
// from the arbiter; psel..pprot/prdata/pready/pslverr the APB4 master interface;
// rd_done/rd_data/rd_resp and wr_done/wr_resp completion to arbiter and response channels;
// busy high while a transfer is in SETUP or ACCESS.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [2:0]          rd_prot,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [2:0]          wr_prot,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                rd_done,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic                busy
);
    localparam int SW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the last ACCESS cycle allowed before expiry
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rd_data_q, rd_data_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic [2:0] pprot_q, pprot_d;
    logic pwrite_q, pwrite_d, rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic [1:0] rd_resp_q, rd_resp_d, wr_resp_q, wr_resp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic expire;
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        wr_resp_d = wr_resp_q;
        cnt_d     = cnt_q;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;
        expire    = (TIMEOUT > 0) && !pready && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                // Read wins when the arbiter erroneously grants both
                if (rd_en) begin
                    state_d  = SETUP;
                    paddr_d  = rd_addr;
                    pprot_d  = rd_prot;
                    pwrite_d = 1'b0;
                    pstrb_d  = '0;
                end else if (wr_en) begin
                    state_d  = SETUP;
                    paddr_d  = wr_addr;
                    pprot_d  = wr_prot;
                    pwrite_d = 1'b1;
                    pwdata_d = wr_data;
                    pstrb_d  = wr_strb;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (pready || expire) begin
                    state_d = IDLE;
                    // A timed-out transfer reports SLVERR and, for reads, zero data
                    if (pwrite_q) begin
                        wr_done_d = 1'b1;
                        wr_resp_d = (!pready || pslverr) ? 2'b10 : 2'b00;
                    end else begin
                        rd_done_d = 1'b1;
                        rd_resp_d = (!pready || pslverr) ? 2'b10 : 2'b00;
                        rd_data_d = pready ? prdata : '0;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            rd_data_q <= '0;
            rd_resp_q <= '0;
            wr_resp_q <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            rd_data_q <= rd_data_d;
            rd_resp_q <= rd_resp_d;
            wr_resp_q <= wr_resp_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            cnt_q     <= cnt_d;
        end
    end
    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign busy    = psel;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pstrb   = pstrb_q;
    assign pprot   = pprot_q;
    assign rd_done = rd_done_q;
    assign rd_data = rd_data_q;
    assign rd_resp = rd_resp_q;
    assign wr_done = wr_done_q;
    assign wr_resp = wr_resp_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard-driven bench for apb_master_ctrl with TIMEOUT=4
module tb_apb_master_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rd_en = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [2:0] rd_prot = '0, wr_prot = '0;
    logic [DW-1:0] wr_data = '0, prdata = '0;
    logic [SW-1:0] wr_strb = '0;
    logic pready = 1'b0, pslverr = 1'b0;
    logic psel, penable, pwrite, rd_done, wr_done, busy;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, rd_data;
    logic [SW-1:0] pstrb;
    logic [2:0] pprot;
    logic [1:0] rd_resp, wr_resp;
    typedef struct packed {
        logic          wr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    int n_done = 0;
    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .rd_en(rd_en), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_prot(rd_prot),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_prot(wr_prot),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp),
        .wr_done(wr_done), .wr_resp(wr_resp), .busy(busy)
    );
    always #5 clk = ~clk;
    // Completion monitor: every done pulse must match the oldest expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (rstn && (rd_done || wr_done)) begin
            n_done++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_done: rd_done=%0b wr_done=%0b, no transfer expected", rd_done, wr_done);
            end else begin
                e = sb.pop_front();
                if ({wr_done, rd_done} !== {e.wr, !e.wr})
                    $display("FAIL sb_done_kind: {wr_done,rd_done}=%b exp %b", {wr_done, rd_done}, {e.wr, !e.wr});
                else if (e.wr && wr_resp !== e.resp)
                    $display("FAIL sb_wr_resp: got %b exp %b", wr_resp, e.resp);
                else if (!e.wr && (rd_resp !== e.resp || rd_data !== e.data))
                    $display("FAIL sb_rd: resp/data got %b/%h exp %b/%h", rd_resp, rd_data, e.resp, e.data);
                else
                    passes++;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rd_done, rd_data, rd_resp, wr_done, wr_resp, busy} !== '0)
            $display("FAIL reset_outputs: psel=%0b penable=%0b paddr=%h busy=%0b not all zero", psel, penable, paddr, busy);
        else passes++;
        rstn = 1'b1;
        tick();
    endtask
    task automatic test_write_zero_wait();
        wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_prot = 3'b010;
        pready = 1'b1; pslverr = 1'b0;
        sb.push_back({1'b1, 32'h0, 2'b00});
        tick();
        wr_en = 1'b0;
        checks++;
        if ({psel, penable, pwrite, busy} !== 4'b1011)
            $display("FAIL wr_setup_ctrl: {psel,penable,pwrite,busy}=%b exp 1011", {psel, penable, pwrite, busy});
        else passes++;
        checks++;
        if ({paddr, pwdata, pstrb, pprot} !== {32'h40, 32'hDEADBEEF, 4'hF, 3'b010})
            $display("FAIL wr_setup_fields: paddr=%h pwdata=%h pstrb=%h pprot=%b", paddr, pwdata, pstrb, pprot);
        else passes++;
        tick();
        checks++;
        if ({psel, penable, wr_done} !== 3'b110)
            $display("FAIL wr_access: {psel,penable,wr_done}=%b exp 110", {psel, penable, wr_done});
        else passes++;
        tick();
        checks++;
        if ({psel, penable, busy, wr_done} !== 4'b0001)
            $display("FAIL wr_done_cycle: {psel,penable,busy,wr_done}=%b exp 0001", {psel, penable, busy, wr_done});
        else passes++;
        tick();
        checks++;
        if (wr_done !== 1'b0) $display("FAIL wr_done_pulse: wr_done=%0b exp 0", wr_done);
        else passes++;
    endtask
    task automatic test_read_wait();
        pready = 1'b0; rd_en = 1'b1; rd_addr = 32'h10; rd_prot = 3'b001;
        sb.push_back({1'b0, 32'h12345678, 2'b10});
        tick();
        rd_en = 1'b0;
        checks++;
        if ({pwrite, paddr, pstrb, pwdata, pprot} !== {1'b0, 32'h10, 4'h0, 32'hDEADBEEF, 3'b001})
            $display("FAIL rd_setup_fields: pwrite=%0b paddr=%h pstrb=%h pwdata=%h pprot=%b", pwrite, paddr, pstrb, pwdata, pprot);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({psel, penable, rd_done} !== 3'b110)
                $display("FAIL rd_wait_%0d: {psel,penable,rd_done}=%b exp 110", i, {psel, penable, rd_done});
            else passes++;
        end
        tick();
        pready = 1'b1; prdata = 32'h12345678; pslverr = 1'b1;
        tick();
        checks++;
        if ({psel, rd_done, wr_done} !== 3'b010)
            $display("FAIL rd_done_time: {psel,rd_done,wr_done}=%b exp 010", {psel, rd_done, wr_done});
        else passes++;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        tick();
    endtask
    task automatic test_simultaneous_b2b();
        pready = 1'b1; prdata = 32'hA5A5A5A5; pslverr = 1'b0;
        rd_en = 1'b1; wr_en = 1'b1; rd_addr = 32'h20; wr_addr = 32'h80; wr_data = 32'h11111111; wr_strb = 4'h3;
        sb.push_back({1'b0, 32'hA5A5A5A5, 2'b00});
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if ({pwrite, paddr, pstrb} !== {1'b0, 32'h20, 4'h0})
            $display("FAIL sim_read_wins: pwrite=%0b paddr=%h pstrb=%h", pwrite, paddr, pstrb);
        else passes++;
        repeat (2) tick();
        checks++;
        if ({psel, rd_done, wr_done} !== 3'b010)
            $display("FAIL sim_done: {psel,rd_done,wr_done}=%b exp 010", {psel, rd_done, wr_done});
        else passes++;
        wr_en = 1'b1; wr_addr = 32'h44; wr_data = 32'hCAFEBABE; wr_strb = 4'hC; pslverr = 1'b1;
        sb.push_back({1'b1, 32'h0, 2'b10});
        tick();
        wr_en = 1'b0;
        checks++;
        if ({psel, penable, pwrite, paddr, pstrb} !== {3'b101, 32'h44, 4'hC})
            $display("FAIL b2b_setup: {psel,penable,pwrite}=%b paddr=%h pstrb=%h", {psel, penable, pwrite}, paddr, pstrb);
        else passes++;
        repeat (2) tick();
        checks++;
        if ({psel, wr_done} !== 2'b01)
            $display("FAIL b2b_done: {psel,wr_done}=%b exp 01", {psel, wr_done});
        else passes++;
        pslverr = 1'b0;
        tick();
    endtask
    task automatic test_timeout();
        pready = 1'b0; prdata = 32'hFFFFFFFF; rd_en = 1'b1; rd_addr = 32'h30;
        sb.push_back({1'b0, 32'h0, 2'b10});
        tick();
        rd_en = 1'b0;
        repeat (4) tick();
        checks++;
        if ({psel, penable, rd_done} !== 3'b110)
            $display("FAIL to_last_access: {psel,penable,rd_done}=%b exp 110", {psel, penable, rd_done});
        else passes++;
        tick();
        checks++;
        if ({psel, rd_done} !== 2'b01)
            $display("FAIL to_expire: {psel,rd_done}=%b exp 01", {psel, rd_done});
        else passes++;
        rd_en = 1'b1; rd_addr = 32'h34;
        sb.push_back({1'b0, 32'hCAFEF00D, 2'b00});
        tick();
        rd_en = 1'b0;
        repeat (4) tick();
        pready = 1'b1; prdata = 32'hCAFEF00D;
        checks++;
        if ({psel, penable, rd_done} !== 3'b110)
            $display("FAIL to_race_access: {psel,penable,rd_done}=%b exp 110", {psel, penable, rd_done});
        else passes++;
        tick();
        checks++;
        if ({psel, rd_done} !== 2'b01)
            $display("FAIL to_race_done: {psel,rd_done}=%b exp 01", {psel, rd_done});
        else passes++;
        pready = 1'b0; prdata = '0;
        tick();
    endtask
    task automatic test_reset_mid_access();
        pready = 1'b0; wr_en = 1'b1; wr_addr = 32'h50; wr_data = 32'h55AA55AA; wr_strb = 4'hF; wr_prot = 3'b111;
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if ({psel, penable} !== 2'b11)
            $display("FAIL rst_pre_access: {psel,penable}=%b exp 11", {psel, penable});
        else passes++;
        rstn = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rd_done, rd_data, rd_resp, wr_done, wr_resp, busy} !== '0)
            $display("FAIL rst_async: psel=%0b penable=%0b paddr=%h pwdata=%h not all zero", psel, penable, paddr, pwdata);
        else passes++;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        pready = 1'b1; wr_en = 1'b1; wr_addr = 32'h54; wr_data = 32'h0BADF00D;
        sb.push_back({1'b1, 32'h0, 2'b00});
        tick();
        wr_en = 1'b0;
        checks++;
        if ({psel, penable, paddr, pwdata} !== {2'b10, 32'h54, 32'h0BADF00D})
            $display("FAIL rst_clean_setup: {psel,penable}=%b paddr=%h pwdata=%h", {psel, penable}, paddr, pwdata);
        else passes++;
        repeat (2) tick();
        checks++;
        if (wr_done !== 1'b1) $display("FAIL rst_clean_done: wr_done=%0b exp 1", wr_done);
        else passes++;
        pready = 1'b0;
        tick();
    endtask
    task automatic test_grant_while_busy();
        int d0;
        d0 = n_done;
        pready = 1'b0; wr_en = 1'b1; wr_addr = 32'h60; wr_data = 32'h12121212;
        sb.push_back({1'b1, 32'h0, 2'b00});
        tick();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 32'h99; rd_en = 1'b1; rd_addr = 32'h98;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({psel, penable, paddr} !== {2'b11, 32'h60})
            $display("FAIL busy_ignore: {psel,penable}=%b paddr=%h exp 11/60", {psel, penable}, paddr);
        else passes++;
        pready = 1'b1;
        tick();
        pready = 1'b0;
        checks++;
        if ({psel, wr_done} !== 2'b01)
            $display("FAIL busy_done: {psel,wr_done}=%b exp 01", {psel, wr_done});
        else passes++;
        repeat (3) tick();
        checks++;
        if (psel !== 1'b0 || n_done - d0 != 1)
            $display("FAIL busy_single: psel=%0b done_pulses=%0d exp 0/1", psel, n_done - d0);
        else passes++;
    endtask
    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_simultaneous_b2b();
        test_timeout();
        test_reset_mid_access();
        test_grant_while_busy();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d expected completions never seen, exp 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
